// File: rtl/ctrl_api_reliability_pkg.sv
// ctrl_api_reliability_pkg: reliability message types, merger FSM states and per-port type legality helpers
package ctrl_api_reliability_pkg;
    localparam int RPM_MSG_TYPE_W = 8;
    localparam logic [RPM_MSG_TYPE_W-1:0] RPM_MSG_TYPE_PUB     = 8'd3;
    localparam logic [RPM_MSG_TYPE_W-1:0] RPM_MSG_TYPE_PUBREC  = 8'd5;
    localparam logic [RPM_MSG_TYPE_W-1:0] RPM_MSG_TYPE_PUBREL  = 8'd6;
    localparam logic [RPM_MSG_TYPE_W-1:0] RPM_MSG_TYPE_PUBCOMP = 8'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD_OB,
        ST_FWD_IB,
        ST_DROP_OB,
        ST_DROP_IB
    } merger_state_t;

    function automatic logic is_outbound_type(input logic [RPM_MSG_TYPE_W-1:0] t);
        return t == RPM_MSG_TYPE_PUB || t == RPM_MSG_TYPE_PUBREL;
    endfunction

    function automatic logic is_inbound_type(input logic [RPM_MSG_TYPE_W-1:0] t);
        return t == RPM_MSG_TYPE_PUBREC || t == RPM_MSG_TYPE_PUBCOMP;
    endfunction
endpackage

// File: rtl/reliability_axis_skid_buffer.sv
// reliability_axis_skid_buffer: 2-entry AXIS register slice with registered s_ready
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready/s_data  upstream handshake and packed beat
//   m_valid/m_ready/m_data  downstream handshake and packed beat (held stable while stalled)
module reliability_axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         acc;

    assign acc = s_valid && s_ready;

    // s_ready is always the inverse of skid occupancy, so a beat can land in the skid only when it is empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            s_ready    <= 1'b0;
        end else if (!m_valid || m_ready) begin
            m_valid    <= skid_valid || acc;
            if (skid_valid || acc) m_data <= skid_valid ? skid_data : s_data;
            skid_valid <= 1'b0;
            s_ready    <= 1'b1;
        end else if (acc) begin
            skid_valid <= 1'b1;
            skid_data  <= s_data;
            s_ready    <= 1'b0;
        end
    end
endmodule

// File: rtl/reliability_to_network_bridge_merger.sv
// reliability_to_network_bridge_merger: packet-level round-robin merge of reliability OB/IB streams to the network bridge
//   i_clk, i_ap_rst_n         clock, asynchronous active-low reset
//   from_rel_outbound_t*      AXIS slave carrying PUB/PUBREL
//   from_rel_inbound_t*       AXIS slave carrying PUBREC/PUBCOMP
//   to_network_bridge_t*      AXIS master, whole packets, no interleaving
//   o_drop_*                  1-cycle pulse per dropped (wrong-type) packet
//   o_drop_cnt_*              saturating dropped-packet counters
module reliability_to_network_bridge_merger
    import ctrl_api_reliability_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH        = 64,
    parameter int AXIS_KEEP_WIDTH        = 8,
    parameter int AXIS_TO_NB_TDEST_WIDTH = 16,
    parameter int AXIS_TO_NB_TUSER_WIDTH = 16,
    parameter int PACKET_MSG_TYPE_WIDTH  = 8,
    parameter int DROP_CNT_WIDTH         = 16
) (
    input  logic                              i_clk,
    input  logic                              i_ap_rst_n,
    input  logic                              from_rel_outbound_tvalid,
    output logic                              from_rel_outbound_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]        from_rel_outbound_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]        from_rel_outbound_tkeep,
    input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rel_outbound_tid,
    input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rel_outbound_tdest,
    input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rel_outbound_tuser,
    input  logic                              from_rel_outbound_tlast,
    input  logic                              from_rel_inbound_tvalid,
    output logic                              from_rel_inbound_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]        from_rel_inbound_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]        from_rel_inbound_tkeep,
    input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rel_inbound_tid,
    input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rel_inbound_tdest,
    input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rel_inbound_tuser,
    input  logic                              from_rel_inbound_tlast,
    output logic                              to_network_bridge_tvalid,
    input  logic                              to_network_bridge_tready,
    output logic [AXIS_DATA_WIDTH-1:0]        to_network_bridge_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]        to_network_bridge_tkeep,
    output logic [AXIS_TO_NB_TDEST_WIDTH-1:0] to_network_bridge_tid,
    output logic [AXIS_TO_NB_TDEST_WIDTH-1:0] to_network_bridge_tdest,
    output logic [AXIS_TO_NB_TUSER_WIDTH-1:0] to_network_bridge_tuser,
    output logic                              to_network_bridge_tlast,
    output logic                              o_drop_outbound,
    output logic                              o_drop_inbound,
    output logic [DROP_CNT_WIDTH-1:0]         o_drop_cnt_outbound,
    output logic [DROP_CNT_WIDTH-1:0]         o_drop_cnt_inbound
);
    localparam int BW = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 2 * AXIS_TO_NB_TDEST_WIDTH + AXIS_TO_NB_TUSER_WIDTH + 1;

    merger_state_t state;
    logic          ptr_ib;
    logic          idle;
    logic          sb_ready;
    logic          sb_push;
    logic          ob_acc;
    logic          ib_acc;
    logic          ob_legal;
    logic          ib_legal;
    logic [BW-1:0] sb_in;
    logic [BW-1:0] sb_out;

    assign idle     = state == ST_IDLE;
    assign ob_legal = is_outbound_type(RPM_MSG_TYPE_W'(from_rel_outbound_tdata[PACKET_MSG_TYPE_WIDTH-1:0]));
    assign ib_legal = is_inbound_type(RPM_MSG_TYPE_W'(from_rel_inbound_tdata[PACKET_MSG_TYPE_WIDTH-1:0]));
    assign ob_acc   = from_rel_outbound_tvalid && from_rel_outbound_tready;
    assign ib_acc   = from_rel_inbound_tvalid && from_rel_inbound_tready;

    // In IDLE each port's ready looks only at the other port's valid and the pointer, never its own valid,
    // so the two readies are mutually exclusive whenever both sources are valid.
    always_comb begin
        from_rel_outbound_tready = idle ? sb_ready && (!ptr_ib || !from_rel_inbound_tvalid)
                                 : state == ST_FWD_OB ? sb_ready : state == ST_DROP_OB;
        from_rel_inbound_tready  = idle ? sb_ready && (ptr_ib || !from_rel_outbound_tvalid)
                                 : state == ST_FWD_IB ? sb_ready : state == ST_DROP_IB;
        sb_push = (ob_acc && (idle ? ob_legal : state == ST_FWD_OB))
               || (ib_acc && (idle ? ib_legal : state == ST_FWD_IB));
        sb_in   = ob_acc ? {from_rel_outbound_tdata, from_rel_outbound_tkeep, from_rel_outbound_tid,
                            from_rel_outbound_tdest, from_rel_outbound_tuser, from_rel_outbound_tlast}
                         : {from_rel_inbound_tdata, from_rel_inbound_tkeep, from_rel_inbound_tid,
                            from_rel_inbound_tdest, from_rel_inbound_tuser, from_rel_inbound_tlast};
    end

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            state               <= ST_IDLE;
            ptr_ib              <= 1'b1;
            o_drop_outbound     <= 1'b0;
            o_drop_inbound      <= 1'b0;
            o_drop_cnt_outbound <= '0;
            o_drop_cnt_inbound  <= '0;
        end else begin
            o_drop_outbound <= idle && ob_acc && !ob_legal;
            o_drop_inbound  <= idle && ib_acc && !ib_legal;
            if (idle && ob_acc && !ob_legal && !(&o_drop_cnt_outbound))
                o_drop_cnt_outbound <= o_drop_cnt_outbound + DROP_CNT_WIDTH'(1);
            if (idle && ib_acc && !ib_legal && !(&o_drop_cnt_inbound))
                o_drop_cnt_inbound <= o_drop_cnt_inbound + DROP_CNT_WIDTH'(1);
            // A tlast beat ends the packet in any state, including a single-beat packet seen in IDLE
            if (ob_acc && from_rel_outbound_tlast) begin
                state  <= ST_IDLE;
                ptr_ib <= 1'b1;
            end else if (ib_acc && from_rel_inbound_tlast) begin
                state  <= ST_IDLE;
                ptr_ib <= 1'b0;
            end else if (idle && ob_acc) begin
                state <= ob_legal ? ST_FWD_OB : ST_DROP_OB;
            end else if (idle && ib_acc) begin
                state <= ib_legal ? ST_FWD_IB : ST_DROP_IB;
            end
        end
    end

    reliability_axis_skid_buffer #(.W(BW)) u_skid (
        .clk     (i_clk),
        .rst_n   (i_ap_rst_n),
        .s_valid (sb_push),
        .s_ready (sb_ready),
        .s_data  (sb_in),
        .m_valid (to_network_bridge_tvalid),
        .m_ready (to_network_bridge_tready),
        .m_data  (sb_out)
    );

    assign {to_network_bridge_tdata, to_network_bridge_tkeep, to_network_bridge_tid,
            to_network_bridge_tdest, to_network_bridge_tuser, to_network_bridge_tlast} = sb_out;
endmodule
